multi_bit_sync_filter: RTL and testbench

Parametrised successor to the fixed 4-bit, 2-stage double-flop synchroniser. It brings a bus of independent, quasi-static single-bit signals (enables, mode bits, status flags) from a foreign domain into the `sync_Clk` domain. It adds:
- a configurable number of synchroniser stages and a configurable reset value;
- an optional per-bit stability filter that rejects pulses shorter than a programmed length;
- per-bit rising and falling edge pulses for downstream control FSMs.

It sits at the receive side of every clock-domain crossing that carries level signals, not data words.

---
 rtl/multi_bit_sync_filter.sv | 98 +++++++++
 tb/tb_multi_bit_sync_filter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_bit_sync_filter.sv
// Receive-side level synchroniser for a bus of independent quasi-static bits,
// with an optional per-bit glitch filter and registered-edge pulse decode.
module multi_bit_sync_filter #(
  parameter int                   BUS_WIDTH  = 4,
  parameter int                   NUM_STAGES = 2,
  parameter int                   FILTER_LEN = 0,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                 sync_Clk,
  input  logic                 sync_Rst,
  input  logic [BUS_WIDTH-1:0] un_sync_in,
  output logic [BUS_WIDTH-1:0] sync_out,
  output logic [BUS_WIDTH-1:0] rise_pulse,
  output logic [BUS_WIDTH-1:0] fall_pulse
);

  generate
    if (BUS_WIDTH < 1) begin : gBadBusWidth
      $error("multi_bit_sync_filter: BUS_WIDTH must be 1 or more");
    end
    if (NUM_STAGES < 2) begin : gBadNumStages
      $error("multi_bit_sync_filter: NUM_STAGES must be 2 or more");
    end
    if ((FILTER_LEN < 0) || (FILTER_LEN > 255)) begin : gBadFilterLen
      $error("multi_bit_sync_filter: FILTER_LEN must be within 0..255");
    end
  endgenerate

  logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stage_q;
  logic [BUS_WIDTH-1:0]                 syncSample;
  logic [BUS_WIDTH-1:0]                 prev_q;

  // Pure flop chain: nothing may sit between stages or MTBF suffers.
  always_ff @(posedge sync_Clk or posedge sync_Rst) begin
    if (sync_Rst) begin
      stage_q <= {NUM_STAGES{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], un_sync_in};
    end
  end

  assign syncSample = stage_q[NUM_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : gNoFilter
      assign sync_out = syncSample;
    end else begin : gFilter
      localparam int             CW       = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
      localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

      logic [BUS_WIDTH-1:0][CW-1:0] cnt_q;
      logic [BUS_WIDTH-1:0][CW-1:0] cnt_d;
      logic [BUS_WIDTH-1:0]         filt_q;
      logic [BUS_WIDTH-1:0]         filt_d;

      // A bit only follows the sample after FILTER_LEN consecutive disagreements.
      always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < BUS_WIDTH; i++) begin
          if (syncSample[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            filt_d[i] = syncSample[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      always_ff @(posedge sync_Clk or posedge sync_Rst) begin
        if (sync_Rst) begin
          cnt_q  <= '0;
          filt_q <= RESET_VAL;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign sync_out = filt_q;
    end
  endgenerate

  always_ff @(posedge sync_Clk or posedge sync_Rst) begin
    if (sync_Rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sync_out;
    end
  end

  // Both operands are flops, so the pulses are glitch-free and mutually exclusive.
  assign rise_pulse = sync_out & ~prev_q;
  assign fall_pulse = ~sync_out & prev_q;

endmodule

// File: tb/tb_multi_bit_sync_filter.sv
// Scoreboard bench: four configurations share one stimulus stream; a queue-based
// reference model predicts levels and pulses, and a monitor compares each cycle.
module tb_multi_bit_sync_filter;

  localparam int         NCFG = 4;
  localparam int         NS_CFG [NCFG] = '{2, 3, 2, 4};
  localparam int         FL_CFG [NCFG] = '{0, 3, 0, 1};
  localparam logic [3:0] RV_CFG [NCFG] = '{4'h0, 4'h0, 4'hF, 4'h5};

  typedef struct packed {
    logic [NCFG-1:0][3:0] out;
    logic [NCFG-1:0][3:0] rise;
    logic [NCFG-1:0][3:0] fall;
  } expT;

  logic       clk;
  logic       rst;
  logic [3:0] unSyncIn;
  logic [3:0] dutOut  [NCFG];
  logic [3:0] dutRise [NCFG];
  logic [3:0] dutFall [NCFG];

  int vecCount  = 0;
  int missCount = 0;

  expT        expQ [$];
  logic [3:0] chainQ [NCFG][$];
  bit         histQ [NCFG*4][$];
  logic [3:0] mOut  [NCFG];
  logic [3:0] mPrev [NCFG];

  multi_bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(0), .RESET_VAL(4'h0)) dutA (
    .sync_Clk(clk), .sync_Rst(rst), .un_sync_in(unSyncIn),
    .sync_out(dutOut[0]), .rise_pulse(dutRise[0]), .fall_pulse(dutFall[0]));

  multi_bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(3), .FILTER_LEN(3), .RESET_VAL(4'h0)) dutB (
    .sync_Clk(clk), .sync_Rst(rst), .un_sync_in(unSyncIn),
    .sync_out(dutOut[1]), .rise_pulse(dutRise[1]), .fall_pulse(dutFall[1]));

  multi_bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(0), .RESET_VAL(4'hF)) dutC (
    .sync_Clk(clk), .sync_Rst(rst), .un_sync_in(unSyncIn),
    .sync_out(dutOut[2]), .rise_pulse(dutRise[2]), .fall_pulse(dutFall[2]));

  multi_bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(4), .FILTER_LEN(1), .RESET_VAL(4'h5)) dutD (
    .sync_Clk(clk), .sync_Rst(rst), .un_sync_in(unSyncIn),
    .sync_out(dutOut[3]), .rise_pulse(dutRise[3]), .fall_pulse(dutFall[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    for (int c = 0; c < NCFG; c++) begin
      chainQ[c].delete();
      for (int k = 0; k < NS_CFG[c]; k++) chainQ[c].push_back(RV_CFG[c]);
      mOut[c]  = RV_CFG[c];
      mPrev[c] = RV_CFG[c];
      for (int b = 0; b < 4; b++) histQ[c*4+b].delete();
    end
  endtask

  // The chain is a delay line; the filter accepts a value once the last
  // FILTER_LEN samples seen since the previous acceptance all disagree.
  task automatic modelStep(input logic [3:0] inVal);
    for (int c = 0; c < NCFG; c++) begin
      logic [3:0] oldS;
      logic [3:0] newOut;
      oldS   = chainQ[c][0];
      newOut = mOut[c];
      if (FL_CFG[c] > 0) begin
        for (int b = 0; b < 4; b++) begin
          int h;
          bit allDiffer;
          h = c*4 + b;
          histQ[h].push_back(oldS[b]);
          if (int'(histQ[h].size()) > FL_CFG[c]) void'(histQ[h].pop_front());
          allDiffer = (int'(histQ[h].size()) == FL_CFG[c]);
          for (int k = 0; k < int'(histQ[h].size()); k++)
            if (histQ[h][k] == mOut[c][b]) allDiffer = 1'b0;
          if (allDiffer) begin
            newOut[b] = oldS[b];
            histQ[h].delete();
          end
        end
      end
      chainQ[c].push_back(inVal);
      void'(chainQ[c].pop_front());
      if (FL_CFG[c] == 0) newOut = chainQ[c][0];
      mPrev[c] = mOut[c];
      mOut[c]  = newOut;
    end
  endtask

  initial begin : modelProc
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else     modelStep(unSyncIn);
    end
  end

  initial begin : pushProc
    expT e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        e.out[c]  = mOut[c];
        e.rise[c] = mOut[c] & ~mPrev[c];
        e.fall[c] = ~mOut[c] & mPrev[c];
      end
      expQ.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  initial begin : monProc
    expT got;
    forever begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
      end else begin
        got = expQ.pop_front();
        for (int c = 0; c < NCFG; c++) begin
          checkOutput($sformatf("cfg%0d_sync_out", c),   dutOut[c],  got.out[c]);
          checkOutput($sformatf("cfg%0d_rise_pulse", c), dutRise[c], got.rise[c]);
          checkOutput($sformatf("cfg%0d_fall_pulse", c), dutFall[c], got.fall[c]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input int cycles);
    unSyncIn = v;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic printSummary();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
  endtask

  initial begin : watchdog
    #1000000;
    missCount++;
    $display("[TB] FAIL watchdog at %0t: got no completion, expected finish", $time);
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimProc
    logic [3:0] cur;
    unSyncIn = 4'h0;
    rst      = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(4'b0000, 6);
    applyStimulus(4'b1010, 8);
    applyStimulus(4'b1000, 8);
    applyStimulus(4'b0001, 8);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b0000, 10);
    applyStimulus(4'b0010, 10);
    applyStimulus(4'b0000, 10);

    // Reset lands while the slow configuration is two samples into a change.
    applyStimulus(4'b0100, 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(4'b0100, 10);

    cur = 4'b0100;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #2 rst = 1'b0;
      end
      cur = cur ^ 4'($urandom_range(0, 15));
      applyStimulus(cur, int'($urandom_range(1, 6)));
    end

    applyStimulus(4'b0000, 12);
    @(negedge clk);
    #2;
    printSummary();
    $finish;
  end

endmodule
